// File: rtl/disp_pkg.sv
// Shared types and constants for the shared display arbiter.
package disp_pkg;

    // Arbiter FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    // Pattern shown while nobody owns the display (dp is active-low: all off).
    localparam logic [15:0] IDLE_HEX = 16'h0000;
    localparam logic [3:0]  IDLE_DP  = 4'b1111;

    // Client index width for the legal client counts 2..4.
    function automatic int idx_width(input int n);
        return (n > 32'sd2) ? 32'sd2 : 32'sd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester found searching upward
// from rr_ptr+1 (mod NREQ). valid is low when no request is present.
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] pick,
    output logic             valid
);

    // Scan the clients in rotation order starting just after the last owner.
    always_comb begin : pick_search
        int idx;
        idx   = 32'sd0;
        pick  = '0;
        valid = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!valid && (|(req & (NREQ'(1'b1) << idx)))) begin
                pick  = IDX_W'(idx);
                valid = 1'b1;
            end else begin
                pick  = pick;
            end
        end
    end

endmodule

// File: rtl/disp_share_arb.sv
// Shared seven-segment display arbiter: req/gnt level handshake, round-robin
// selection with a minimum hold time, idle pattern when nobody owns the display.
// Optional feature macro DISP_PRIO_EN: client 0 becomes high priority
// (preempts other owners immediately and wins every pick).
module disp_share_arb
    import disp_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int HOLD_CYC = 10_000_000,
    parameter int HOLD_W   = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [16*NREQ-1:0]  hex_bus,
    input  logic [4*NREQ-1:0]   dp_bus,
    output logic [NREQ-1:0]     gnt,
    output logic [3:0]          hex3,
    output logic [3:0]          hex2,
    output logic [3:0]          hex1,
    output logic [3:0]          hex0,
    output logic [3:0]          dp_out,
    output logic                busy
);

    localparam int                IDX_W    = idx_width(NREQ);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_CYC);

    state_t              state_r;
    logic [IDX_W-1:0]    owner_r;
    logic [IDX_W-1:0]    rr_ptr_r;
    logic [HOLD_W-1:0]   hold_cnt_r;

    logic [IDX_W-1:0]    rr_pick_s;
    logic [IDX_W-1:0]    pick_s;
    logic                pick_valid_s;
    logic [NREQ-1:0]     pick_oh_s;
    logic [NREQ-1:0]     own_oh_s;
    logic [15:0]         own_hex_s;
    logic [3:0]          own_dp_s;
    logic                own_req_s;
    logic                other_req_s;
    logic                slice_end_s;
    logic                prio_hit_s;
    logic                release_s;
    logic                rr_upd_s;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_r),
        .pick   (rr_pick_s),
        .valid  (pick_valid_s)
    );

    // Owner slice selection, one-hot decodes and the release/preempt decision.
    always_comb begin
        own_hex_s = IDLE_HEX;
        own_dp_s  = IDLE_DP;
        own_oh_s  = '0;
        pick_oh_s = '0;
`ifdef DISP_PRIO_EN
        // Client 0 wins every pick and cuts any other owner short.
        pick_s     = req[0] ? '0 : rr_pick_s;
        prio_hit_s = req[0] && (owner_r != '0);
        rr_upd_s   = (owner_r != '0);
`else
        pick_s     = rr_pick_s;
        prio_hit_s = 1'b0;
        rr_upd_s   = 1'b1;
`endif
        for (int i = 0; i < NREQ; i++) begin
            pick_oh_s[i] = (pick_s == IDX_W'(i));
            if (owner_r == IDX_W'(i)) begin
                own_oh_s[i] = 1'b1;
                own_hex_s   = hex_bus[16*i +: 16];
                own_dp_s    = dp_bus[4*i +: 4];
            end else begin
                own_oh_s[i] = 1'b0;
            end
        end
        own_req_s   = |(req & own_oh_s);
        other_req_s = |(req & ~own_oh_s);
        // Time-slice expiry only matters when someone else is waiting.
        slice_end_s = (hold_cnt_r == HOLD_LIM) && other_req_s;
        release_s   = !own_req_s || slice_end_s || prio_hit_s;
    end

    // Arbiter FSM with registered grant, display data and busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            gnt        <= '0;
            owner_r    <= '0;
            hold_cnt_r <= '0;
            rr_ptr_r   <= IDX_W'(NREQ - 1);
            {hex3, hex2, hex1, hex0} <= IDLE_HEX;
            dp_out     <= IDLE_DP;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        gnt        <= pick_oh_s;
                        owner_r    <= pick_s;
                        hold_cnt_r <= '0;
                        busy       <= 1'b1;
                        state_r    <= ST_GRANT;
                    end else begin
                        gnt        <= '0;
                        busy       <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // Owner data follows gnt by one cycle.
                    {hex3, hex2, hex1, hex0} <= own_hex_s;
                    dp_out <= own_dp_s;
                    if (hold_cnt_r != HOLD_LIM) begin
                        hold_cnt_r <= hold_cnt_r + 1'b1;
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                    if (release_s) begin
                        gnt     <= '0;
                        state_r <= ST_SWITCH;
                        if (rr_upd_s) begin
                            rr_ptr_r <= owner_r;
                        end else begin
                            rr_ptr_r <= rr_ptr_r;
                        end
                    end else begin
                        state_r <= ST_GRANT;
                    end
                end
                ST_SWITCH: begin
                    // Display keeps its last value through the dead cycle.
                    if (pick_valid_s) begin
                        gnt        <= pick_oh_s;
                        owner_r    <= pick_s;
                        hold_cnt_r <= '0;
                        state_r    <= ST_GRANT;
                    end else begin
                        gnt        <= '0;
                        busy       <= 1'b0;
                        {hex3, hex2, hex1, hex0} <= IDLE_HEX;
                        dp_out     <= IDLE_DP;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    gnt     <= '0;
                    busy    <= 1'b0;
                    {hex3, hex2, hex1, hex0} <= IDLE_HEX;
                    dp_out  <= IDLE_DP;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_share_arb.sv
// Self-checking bench for disp_share_arb (NREQ=2, HOLD_CYC=8) using a
// queue of per-cycle expected outputs.
module tb_disp_share_arb;

    localparam int NREQ = 2;

    typedef struct {
        logic [1:0]  gnt;
        logic [15:0] hex;
        logic [3:0]  dp;
        logic        busy;
    } exp_t;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [16*NREQ-1:0]  hex_bus;
    logic [4*NREQ-1:0]   dp_bus;
    logic [NREQ-1:0]     gnt;
    logic [3:0]          hex3, hex2, hex1, hex0;
    logic [3:0]          dp_out;
    logic                busy;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    disp_share_arb #(
        .NREQ     (2),
        .HOLD_CYC (8),
        .HOLD_W   (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .hex_bus (hex_bus),
        .dp_bus  (dp_bus),
        .gnt     (gnt),
        .hex3    (hex3),
        .hex2    (hex2),
        .hex1    (hex1),
        .hex0    (hex0),
        .dp_out  (dp_out),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic [15:0] h, input logic [3:0] d,
                        input logic b, input int n);
        exp_t e;
        e.gnt  = g;
        e.hex  = h;
        e.dp   = d;
        e.busy = b;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic run_cycles(input int n);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            cyc++;
            chk($sformatf("sb_avail@%0d", cyc), 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk($sformatf("gnt@%0d", cyc), 32'(gnt), 32'(e.gnt));
                chk($sformatf("hex@%0d", cyc), 32'({hex3, hex2, hex1, hex0}), 32'(e.hex));
                chk($sformatf("dp@%0d", cyc), 32'(dp_out), 32'(e.dp));
                chk($sformatf("busy@%0d", cyc), 32'(busy), 32'(e.busy));
            end
        end
    endtask

    task automatic chk_idle_now(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_hex"}, 32'({hex3, hex2, hex1, hex0}), 32'h0000);
        chk({tag, "_dp"}, 32'(dp_out), 32'hF);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        req     = 2'b00;
        hex_bus = {16'hABCD, 16'h1234};
        dp_bus  = {4'b1001, 4'b0110};

        // Reset state, then idle after release with no requests.
        repeat (2) @(posedge clk);
        #1;
        chk_idle_now("rst");
        reset = 1'b0;
        push(2'b00, 16'h0000, 4'hF, 1'b0, 2);
        run_cycles(2);

        // Lone requester: grant after 1 clk, data 1 clk later, kept past hold.
        req = 2'b01;
        push(2'b01, 16'h0000, 4'hF, 1'b1, 1);
        push(2'b01, 16'h1234, 4'h6, 1'b1, 11);
        run_cycles(12);

        // Release with no other request: SWITCH then IDLE pattern.
        req = 2'b00;
        push(2'b00, 16'h1234, 4'h6, 1'b1, 1);
        push(2'b00, 16'h0000, 4'hF, 1'b0, 2);
        run_cycles(3);

        // Fresh reset, then both clients: time-sliced rotation.
        reset = 1'b1;
        req   = 2'b11;
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(2'b01, 16'h0000, 4'hF, 1'b1, 1);
        push(2'b01, 16'h1234, 4'h6, 1'b1, 8);
        push(2'b00, 16'h1234, 4'h6, 1'b1, 1);
        push(2'b10, 16'h1234, 4'h6, 1'b1, 1);
        push(2'b10, 16'hABCD, 4'h9, 1'b1, 8);
        push(2'b00, 16'hABCD, 4'h9, 1'b1, 1);
        push(2'b01, 16'hABCD, 4'h9, 1'b1, 1);
        push(2'b01, 16'h1234, 4'h6, 1'b1, 2);
        run_cycles(23);

        // Client 0 drops early (before hold expiry) with nobody else waiting.
        req = 2'b00;
        push(2'b00, 16'h1234, 4'h6, 1'b1, 1);
        push(2'b00, 16'h0000, 4'hF, 1'b0, 2);
        run_cycles(3);

        // Owner drops and the other client raises on the same edge.
        req = 2'b01;
        push(2'b01, 16'h0000, 4'hF, 1'b1, 1);
        push(2'b01, 16'h1234, 4'h6, 1'b1, 1);
        run_cycles(2);
        req = 2'b10;
        push(2'b00, 16'h1234, 4'h6, 1'b1, 1);
        push(2'b10, 16'h1234, 4'h6, 1'b1, 1);
        push(2'b10, 16'hABCD, 4'h9, 1'b1, 1);
        run_cycles(3);

        // Asynchronous reset mid-grant, between clock edges.
        #3;
        reset = 1'b1;
        #1;
        chk_idle_now("async_rst");
        @(posedge clk);
        #1;
        chk("rst_hold_gnt", 32'(gnt), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_rel_gnt", 32'(gnt), 32'd0);
        push(2'b10, 16'h0000, 4'hF, 1'b1, 1);
        push(2'b10, 16'hABCD, 4'h9, 1'b1, 2);
        run_cycles(3);

        // Client 0 raises while client 1 owns well before hold expiry.
        req = 2'b11;
`ifdef DISP_PRIO_EN
        push(2'b00, 16'hABCD, 4'h9, 1'b1, 1);
        push(2'b01, 16'hABCD, 4'h9, 1'b1, 1);
        push(2'b01, 16'h1234, 4'h6, 1'b1, 1);
`else
        push(2'b10, 16'hABCD, 4'h9, 1'b1, 3);
`endif
        run_cycles(3);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
